// File: rtl/apb_master_ctrl.sv
// APB initiator: turns a valid/ready command port into APB SETUP/ACCESS
// transfers and returns read data and slave error on a one-cycle response
// strobe. It also edge-detects the peripheral IRQ level.
//
// Optional build macro: APB_TIMEOUT_EN
//   defined   - a wait-state watchdog aborts an ACCESS phase after
//               TIMEOUT_CYCLES consecutive PREADY-low cycles.
//   undefined - ACCESS waits indefinitely and rsp_timeout is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus idle, cmd_ready high, PSEL/PENABLE low
// SETUP  | APB setup phase, PSEL high, PENABLE low, exactly one cycle
// ACCESS | APB access phase, PSEL/PENABLE high until PREADY (or abort)

module apb_master_ctrl #(
   parameter int ADDR_W         = 5,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   // command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   // response side
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   // APB bus
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PWRITE,
   output logic              PSEL,
   output logic              PENABLE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   // interrupt
   input  logic              IRQ,
   output logic              irq_rise
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   // A zero watchdog limit would abort before the first ACCESS cycle.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_ctrl: TIMEOUT_CYCLES must be >= 1");
   end

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] paddr_q,     paddr_d;
   logic [DATA_W-1:0] pwdata_q,    pwdata_d;
   logic              pwrite_q,    pwrite_d;
   logic              psel_q,      psel_d;
   logic              penable_q,   penable_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;
   logic              irq_q;
   logic              irq_rise_q;

   // Watchdog abort request for the current ACCESS cycle (PREADY low only).
   logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
   localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              xfer_done;

   assign timeout_hit = (state_q == ST_ACCESS) && !PREADY &&
                        (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));
   assign xfer_done   = (state_q == ST_ACCESS) && (PREADY || timeout_hit);

   // Wait-state counter: cleared in SETUP, counts PREADY-low ACCESS cycles.
   always_comb begin
      wcnt_d = wcnt_q;
      if (state_q == ST_SETUP) begin
         wcnt_d = '0;
      end else if ((state_q == ST_ACCESS) && !PREADY && !timeout_hit) begin
         wcnt_d = wcnt_q + WCNT_W'(1);
      end
   end

   // Timeout flag follows each completion and holds until the next one.
   always_comb begin
      rsp_timeout_d = rsp_timeout_q;
      if (xfer_done) begin
         rsp_timeout_d = timeout_hit;
      end
   end

   // Watchdog registers.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         wcnt_q        <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         wcnt_q        <= wcnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign rsp_timeout = rsp_timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   // Transfer sequencing and next values of all registered bus/response outputs.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               if (cmd_write) begin
                  pwdata_d = cmd_wdata;
               end
               psel_d   = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = ST_IDLE;
            end else if (timeout_hit) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // FSM, APB bus and response registers.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // IRQ synchroniser stage and rising-edge pulse.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         irq_q      <= 1'b0;
         irq_rise_q <= 1'b0;
      end else begin
         irq_q      <= IRQ;
         irq_rise_q <= IRQ & ~irq_q;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PWRITE    = pwrite_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign irq_rise  = irq_rise_q;

endmodule
